// File: rtl/boot_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : boot_mem_ctrl_pkg
//  Purpose : Shared FSM state encoding and default parameter values for the
//            boot memory controller and its sub-blocks.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package boot_mem_ctrl_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_IM_AW  = 8;
    localparam int DEF_DM_AW  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

endpackage : boot_mem_ctrl_pkg
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// ============================================================================
//  Module  : sp_ram
//  Purpose : Word memory with one synchronous write port and one
//            combinational read port. Contents have no reset.
//  Ports   : clk   - write clock
//            we    - write enable
//            waddr - write address
//            wdata - write word
//            raddr - read address
//            rdata - read word (combinational)
//  Rev     : 1.0  initial release
// ============================================================================
module sp_ram #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : sp_ram
`default_nettype wire

// File: rtl/boot_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : boot_mem_ctrl
//  Purpose : Boot controller: loads a program into the instruction memory
//            from a valid/ready word stream, then gates a simple core
//            (run / halt / resume) and owns the core's data memory.
//  Ports   : clock, reset (async, active low)
//            load_start/load_len/load_valid/load_data/load_ready - load stream
//            run_start, cpu_halt                      - run control
//            cpu_pc/cpu_instr                         - instruction fetch
//            cpu_d_addr/cpu_d_we/cpu_d_wdata/cpu_d_rdata - data memory
//            cpu_enable, state, load_count, load_done, error - status
//  Rev     : 1.0  initial release
// ============================================================================
module boot_mem_ctrl
    import boot_mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IM_AW  = DEF_IM_AW,
    parameter int DM_AW  = DEF_DM_AW
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_start,
    input  logic [IM_AW:0]    load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    input  logic              run_start,
    input  logic              cpu_halt,
    input  logic [IM_AW-1:0]  cpu_pc,
    output logic [DATA_W-1:0] cpu_instr,
    input  logic [DM_AW-1:0]  cpu_d_addr,
    input  logic              cpu_d_we,
    input  logic [DATA_W-1:0] cpu_d_wdata,
    output logic [DATA_W-1:0] cpu_d_rdata,
    output logic              cpu_enable,
    output logic [1:0]        state,
    output logic [IM_AW:0]    load_count,
    output logic              load_done,
    output logic              error
);

    localparam int             DEPTH_I = 1 << IM_AW;
    localparam logic [IM_AW:0] DEPTH   = DEPTH_I[IM_AW:0];

    // Reset asserts immediately, releases two edges after deassertion.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    state_t         cur_state, nxt_state;
    logic [IM_AW:0] cnt_q, cnt_d;
    logic [IM_AW:0] len_q, len_d;
    logic           loaded_q, loaded_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           im_we;
    logic           dm_we;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            loaded_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            loaded_q  <= loaded_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        cnt_d     = cnt_q;
        len_d     = len_q;
        loaded_d  = loaded_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        im_we     = 1'b0;

        case (cur_state)
            ST_IDLE, ST_HALT: begin
                // load_start has priority over run_start.
                if (load_start) begin
                    nxt_state = ST_LOAD;
                    cnt_d     = '0;
                    loaded_d  = 1'b0;
                    if ((load_len == '0) || (load_len > DEPTH)) begin
                        len_d = DEPTH;
                    end else begin
                        len_d = load_len;
                    end
                    err_d = (load_len > DEPTH);
                end else if (run_start) begin
                    // Resume from HALT is unconditional; a fresh start
                    // needs a completed load.
                    if ((cur_state == ST_HALT) || loaded_q) begin
                        nxt_state = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_LOAD: begin
                if (load_start) begin
                    err_d = 1'b1;
                end
                // Count guard keeps load_count saturated at the length.
                if (load_valid && (cnt_q < len_q)) begin
                    im_we = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == (len_q - 1'b1)) begin
                        nxt_state = ST_IDLE;
                        loaded_d  = 1'b1;
                        done_d    = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (load_start) begin
                    err_d = 1'b1;
                end
                // Halt wins over a simultaneous run_start.
                if (cpu_halt) begin
                    nxt_state = ST_HALT;
                end
            end

            default: begin
                nxt_state = ST_IDLE;
            end
        endcase
    end

    assign dm_we      = cpu_d_we && (cur_state == ST_RUN);
    assign load_ready = (cur_state == ST_LOAD);
    assign cpu_enable = (cur_state == ST_RUN);
    assign state      = cur_state;
    assign load_count = cnt_q;
    assign load_done  = done_q;
    assign error      = err_q;

    // IM writes come from the load counter; fetches always use cpu_pc.
    sp_ram #(
        .AW (IM_AW),
        .DW (DATA_W)
    ) u_im (
        .clk   (clock),
        .we    (im_we),
        .waddr (cnt_q[IM_AW-1:0]),
        .wdata (load_data),
        .raddr (cpu_pc),
        .rdata (cpu_instr)
    );

    sp_ram #(
        .AW (DM_AW),
        .DW (DATA_W)
    ) u_dm (
        .clk   (clock),
        .we    (dm_we),
        .waddr (cpu_d_addr),
        .wdata (cpu_d_wdata),
        .raddr (cpu_d_addr),
        .rdata (cpu_d_rdata)
    );

endmodule : boot_mem_ctrl
`default_nettype wire

// File: tb/tb_boot_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_boot_mem_ctrl
//  Purpose : Self-checking bench for boot_mem_ctrl: directed scenarios plus
//            a randomized phase, all checked against a behavioural model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_boot_mem_ctrl;

    localparam int DATA_W = 16;
    localparam int IM_AW  = 3;
    localparam int DM_AW  = 4;
    localparam int DEPTH  = 1 << IM_AW;
    localparam int DMD    = 1 << DM_AW;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              load_start = 1'b0;
    logic [IM_AW:0]    load_len = '0;
    logic              load_valid = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_ready;
    logic              run_start = 1'b0;
    logic              cpu_halt = 1'b0;
    logic [IM_AW-1:0]  cpu_pc = '0;
    logic [DATA_W-1:0] cpu_instr;
    logic [DM_AW-1:0]  cpu_d_addr = '0;
    logic              cpu_d_we = 1'b0;
    logic [DATA_W-1:0] cpu_d_wdata = '0;
    logic [DATA_W-1:0] cpu_d_rdata;
    logic              cpu_enable;
    logic [1:0]        state;
    logic [IM_AW:0]    load_count;
    logic              load_done;
    logic              error;

    boot_mem_ctrl #(
        .DATA_W (DATA_W),
        .IM_AW  (IM_AW),
        .DM_AW  (DM_AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load_start  (load_start),
        .load_len    (load_len),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .run_start   (run_start),
        .cpu_halt    (cpu_halt),
        .cpu_pc      (cpu_pc),
        .cpu_instr   (cpu_instr),
        .cpu_d_addr  (cpu_d_addr),
        .cpu_d_we    (cpu_d_we),
        .cpu_d_wdata (cpu_d_wdata),
        .cpu_d_rdata (cpu_d_rdata),
        .cpu_enable  (cpu_enable),
        .state       (state),
        .load_count  (load_count),
        .load_done   (load_done),
        .error       (error)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model: mode name as integer 0..3, memories as arrays.
    int          m_state  = 0;
    int          m_cnt    = 0;
    int          m_len    = 0;
    bit          m_loaded = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_done   = 1'b0;
    logic [15:0] im_m [DEPTH];
    bit          im_v [DEPTH];
    logic [15:0] dm_m [DMD];
    bit          dm_v [DMD];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int ll;
        ll     = int'(load_len);
        m_err  = 1'b0;
        m_done = 1'b0;
        if (m_state == 0 || m_state == 3) begin
            if (load_start) begin
                m_state  = 1;
                m_cnt    = 0;
                m_loaded = 1'b0;
                m_len    = (ll == 0 || ll > DEPTH) ? DEPTH : ll;
                m_err    = (ll > DEPTH);
            end else if (run_start) begin
                if (m_state == 3 || m_loaded) m_state = 2;
                else m_err = 1'b1;
            end
        end else if (m_state == 1) begin
            if (load_start) m_err = 1'b1;
            if (load_valid && m_cnt < m_len) begin
                im_m[m_cnt] = load_data;
                im_v[m_cnt] = 1'b1;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_state  = 0;
                    m_loaded = 1'b1;
                    m_done   = 1'b1;
                end
            end
        end else begin
            if (load_start) m_err = 1'b1;
            if (cpu_d_we) begin
                dm_m[cpu_d_addr] = cpu_d_wdata;
                dm_v[cpu_d_addr] = 1'b1;
            end
            if (cpu_halt) m_state = 3;
        end
    endtask

    task automatic compare_all();
        check("state", 32'(state), 32'(m_state));
        check("load_count", 32'(load_count), 32'(m_cnt));
        check("load_ready", 32'(load_ready), 32'(m_state == 1));
        check("cpu_enable", 32'(cpu_enable), 32'(m_state == 2));
        check("load_done", 32'(load_done), 32'(m_done));
        check("error", 32'(error), 32'(m_err));
        if (im_v[cpu_pc]) check("cpu_instr", 32'(cpu_instr), 32'(im_m[cpu_pc]));
        if (dm_v[cpu_d_addr]) check("cpu_d_rdata", 32'(cpu_d_rdata), 32'(dm_m[cpu_d_addr]));
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        load_start = 1'b0;
        run_start  = 1'b0;
        cpu_halt   = 1'b0;
        load_valid = 1'b0;
        cpu_d_we   = 1'b0;
    endtask

    // Reset is asserted mid-cycle and checked before any clock edge.
    task automatic do_reset();
        idle_inputs();
        #1;
        reset = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_enable", 32'(cpu_enable), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        m_state  = 0;
        m_cnt    = 0;
        m_len    = 0;
        m_loaded = 1'b0;
        m_err    = 1'b0;
        m_done   = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) tick();
    endtask

    task automatic pulse_start(input int len);
        load_start = 1'b1;
        load_len   = (IM_AW+1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    // Feeds words until the block leaves LOAD; toggle selects 1/0 valid.
    task automatic feed(input bit toggle, output int ready_cycles, output int done_pulses);
        int guard;
        ready_cycles = 0;
        done_pulses  = 0;
        guard        = 0;
        while (load_ready && guard < 200) begin
            ready_cycles++;
            load_valid = toggle ? ((guard % 2) == 0) : 1'b1;
            load_data  = 16'($urandom);
            cpu_pc     = IM_AW'($urandom);
            tick();
            if (load_done) done_pulses++;
            guard++;
        end
        load_valid = 1'b0;
        check("load_timeout", 32'(guard < 200), 32'd1);
    endtask

    int rc, dp;

    initial begin
        for (int i = 0; i < DEPTH; i++) im_v[i] = 1'b0;
        for (int i = 0; i < DMD; i++) dm_v[i] = 1'b0;

        #3;
        do_reset();

        // Run without a load must be refused.
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("run_noload_err", 32'(error), 32'd1);
        check("run_noload_state", 32'(state), 32'd0);

        // Full load of four fixed words, valid held high.
        load_start = 1'b1;
        load_len   = 4'd4;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = 16'(16'h1111 * (i + 1));
            tick();
        end
        load_valid = 1'b0;
        check("full_state", 32'(state), 32'd0);
        check("full_done", 32'(load_done), 32'd1);
        tick();
        check("full_done_once", 32'(load_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cpu_pc = IM_AW'(i);
            #1;
            check("full_im", 32'(cpu_instr), 32'(16'h1111 * (i + 1)));
        end

        // Same length via feed to verify the ready window.
        pulse_start(4);
        feed(1'b0, rc, dp);
        check("ready_cycles4", 32'(rc), 32'd4);
        check("done_pulses4", 32'(dp), 32'd1);

        // Backpressure: 1/0 valid on a 3-word load.
        pulse_start(3);
        feed(1'b1, rc, dp);
        check("bp_ready_cycles", 32'(rc), 32'd5);
        check("bp_done", 32'(dp), 32'd1);
        check("bp_count", 32'(load_count), 32'd3);

        // Run gating after a completed load.
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("run_state", 32'(state), 32'd2);
        check("run_enable", 32'(cpu_enable), 32'd1);

        // DM write in RUN stores, in HALT is dropped.
        cpu_d_addr  = 4'h5;
        cpu_d_we    = 1'b1;
        cpu_d_wdata = 16'hA5A5;
        tick();
        cpu_d_we = 1'b0;
        check("dm_run_write", 32'(cpu_d_rdata), 32'hA5A5);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("ls_in_run_err", 32'(error), 32'd1);
        cpu_halt = 1'b1;
        tick();
        cpu_halt = 1'b0;
        check("halt_state", 32'(state), 32'd3);
        check("halt_enable", 32'(cpu_enable), 32'd0);
        cpu_d_we    = 1'b1;
        cpu_d_wdata = 16'h5A5A;
        tick();
        cpu_d_we = 1'b0;
        check("dm_halt_drop", 32'(cpu_d_rdata), 32'hA5A5);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("resume_state", 32'(state), 32'd2);
        cpu_d_we = 1'b1;
        tick();
        cpu_d_we = 1'b0;
        check("dm_run_write2", 32'(cpu_d_rdata), 32'h5A5A);

        // Halt beats a simultaneous run_start.
        cpu_halt  = 1'b1;
        run_start = 1'b1;
        tick();
        idle_inputs();
        check("halt_wins", 32'(state), 32'd3);

        // load_start beats run_start in HALT without an error.
        load_start = 1'b1;
        run_start  = 1'b1;
        load_len   = 4'd2;
        tick();
        idle_inputs();
        check("ls_wins_state", 32'(state), 32'd1);
        check("ls_wins_noerr", 32'(error), 32'd0);
        feed(1'b0, rc, dp);

        // Reset after two of four words.
        pulse_start(4);
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 16'($urandom);
            tick();
        end
        load_valid = 1'b0;
        do_reset();
        check("rst_load_state", 32'(state), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        check("rst_load_run_err", 32'(error), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            cpu_pc = IM_AW'(i);
            #1;
            if (im_v[i]) check("im_retained", 32'(cpu_instr), 32'(im_m[i]));
        end

        // Length boundaries: 0 means full depth, 9 saturates with error.
        pulse_start(0);
        feed(1'b0, rc, dp);
        check("len0_count", 32'(load_count), 32'd8);
        check("len0_ready", 32'(rc), 32'd8);
        pulse_start(9);
        check("len9_err", 32'(error), 32'd1);
        feed(1'b0, rc, dp);
        check("len9_count", 32'(load_count), 32'd8);

        // Randomized phase.
        for (int c = 0; c < 600; c++) begin
            load_start  = ($urandom_range(0, 99) < 6);
            load_len    = (IM_AW+1)'($urandom_range(0, 10));
            run_start   = ($urandom_range(0, 99) < 12);
            cpu_halt    = ($urandom_range(0, 99) < 10);
            load_valid  = ($urandom_range(0, 99) < 60);
            load_data   = 16'($urandom);
            cpu_pc      = IM_AW'($urandom);
            cpu_d_addr  = DM_AW'($urandom);
            cpu_d_we    = ($urandom_range(0, 99) < 35);
            cpu_d_wdata = 16'($urandom);
            tick();
        end
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_boot_mem_ctrl
`default_nettype wire

// File: doc/boot_mem_ctrl.md
BOOT_MEM_CTRL -- requirements
Module: boot_mem_ctrl

Interface
REQ-001 The block SHALL take these parameters:
- DATA_W, 16, word width of both memories.
- IM_AW, 8, instruction-memory address width; depth 2**IM_AW.
- DM_AW, 8, data-memory address width; depth 2**DM_AW.

REQ-002 The block SHALL have these ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse: begin a program load.
- load_len  in  IM_AW+1  number of words to load; 0 means full depth.
- load_valid  in  1  load word present.
- load_data  in  DATA_W  load word.
- load_ready  out  1  block accepts the load word.
- run_start  in  1  pulse: start or resume the core.
- cpu_halt  in  1  core requests stop.
- cpu_pc  in  IM_AW  core fetch address.
- cpu_instr  out  DATA_W  instruction at cpu_pc.
- cpu_d_addr  in  DM_AW  data address.
- cpu_d_we  in  1  data write enable.
- cpu_d_wdata  in  DATA_W  data write word.
- cpu_d_rdata  out  DATA_W  data at cpu_d_addr.
- cpu_enable  out  1  core clock-enable.
- state  out  2  FSM state.
- load_count  out  IM_AW+1  words written in the current or last load.
- load_done  out  1  one-cycle pulse at load completion.
- error  out  1  one-cycle pulse on an illegal request.

Function
REQ-003 The FSM SHALL have four states, encoded on `state`: IDLE=0, LOAD=1, RUN=2, HALT=3.
REQ-004 In IDLE or HALT, load_start SHALL move the FSM to LOAD, clear load_count, clear the loaded flag, and latch the effective length: load_len, or 2**IM_AW when load_len is 0 or exceeds 2**IM_AW.
REQ-005 A load_len above 2**IM_AW SHALL additionally pulse `error` in the cycle after load_start.
REQ-006 load_ready SHALL be 1 exactly while in LOAD.
- A word is accepted on an edge where load_valid and load_ready are both 1.
- The word is written to IM[load_count] on that edge, and load_count increments by 1.
REQ-007 On acceptance of the final word (load_count = length-1 before the edge), the FSM SHALL go to IDLE, set the loaded flag, and pulse load_done for the next cycle only.
REQ-008 load_start while in LOAD or RUN SHALL be ignored and SHALL pulse `error`.
REQ-009 run_start in IDLE SHALL go to RUN if the loaded flag is 1; otherwise the FSM SHALL stay in IDLE and pulse `error`.
REQ-010 run_start in HALT SHALL return to RUN; the core's pc is not touched.
REQ-011 cpu_enable SHALL be 1 only in RUN.
REQ-012 cpu_halt in RUN SHALL take the FSM to HALT on the next edge.
REQ-013 If run_start and cpu_halt are simultaneous in RUN, cpu_halt wins.
REQ-014 If load_start and run_start are simultaneous in IDLE/HALT, load_start wins and no error is raised.
REQ-015 The IM read port SHALL be combinational: cpu_instr = IM[cpu_pc] in all states.
- During LOAD, the IM address mux SHALL select load_count[IM_AW-1:0] for writes only; reads still use cpu_pc.
REQ-016 DM SHALL read combinationally (cpu_d_rdata = DM[cpu_d_addr]) and write synchronously.
- A DM write occurs only when cpu_d_we=1 and state=RUN; writes in any other state are dropped.
REQ-017 load_count SHALL saturate at the effective length and never wrap.

Reset
REQ-018 Asserting reset (low) SHALL immediately set:
- state=IDLE, load_count=0, loaded flag=0;
- load_ready=0, cpu_enable=0, load_done=0, error=0.
REQ-019 Memory contents SHALL NOT be cleared by reset.
- A reset during LOAD leaves the words already written intact, but loaded=0, so run_start pulses `error` until a new load completes.
REQ-020 Deassertion SHALL be synchronised internally (two-flop) before it releases the FSM.

Structure
REQ-021 The FSM state encodings and default parameter values SHALL live in the shared package.
REQ-022 Both memories SHALL be instances of one sub-module, sp_ram:
- parameters AW and DW;
- synchronous write, combinational read.
- Instantiated as u_im and u_dm.

Verification
REQ-023 Full load: load_len=4, four words 0x1111..0x4444 with valid held high.
- load_ready is 1 for 4 cycles.
- load_done pulses once.
- IM[0..3] hold the loaded words; state returns to 0.
REQ-024 Backpressure: load_valid toggled 1/0 during a load_len=3 load -> load_count increments only on valid cycles; completion occurs after 3 accepted words.
REQ-025 Run gating: run_start without a prior load -> error pulse and state stays 0. After a completed load, run_start -> state=2 and cpu_enable=1.
REQ-026 Halt/resume and DM protection:
- cpu_halt -> state=3 and cpu_enable=0.
- A DM write to address 0x05 in HALT is dropped; the same write in RUN stores the word.
- run_start -> state=2.
REQ-027 Reset during LOAD after 2 of 4 words -> state=0, load_count=0. A following run_start pulses error.
REQ-028 Boundary: load_len=0 with IM_AW=3 -> 8 words accepted, load_count=8. load_len=9 -> error pulse and 8 words accepted.
